// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline stage: two-entry (main + skid) buffer with a valid/ready handshake.
// Define ID_EX_WB_REFRESH_EN to refresh held operands from the write-back bus while they wait.
module id_ex_stage #(
  parameter int unsigned CTRL_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [31:0]       pc_d,
  input  logic [31:0]       rd1_d,
  input  logic [31:0]       rd2_d,
  input  logic [31:0]       imm_d,
  input  logic [4:0]        rs1_d,
  input  logic [4:0]        rs2_d,
  input  logic [4:0]        rd_d,
  input  logic [CTRL_W-1:0] ctrl_d,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_rd,
  input  logic [31:0]       wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       pc_e,
  output logic [31:0]       rd1_e,
  output logic [31:0]       rd2_e,
  output logic [31:0]       imm_e,
  output logic [4:0]        rs1_e,
  output logic [4:0]        rs2_e,
  output logic [4:0]        rd_e,
  output logic [CTRL_W-1:0] ctrl_e
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  logic [1:0] state_q, state_d;
  entry_t     main_q, main_d;
  entry_t     skid_q, skid_d;
  entry_t     in_e;
  logic       in_fire, out_fire;

  // Patch an operand whose source register is being written back this cycle; x0 is never patched.
  function automatic entry_t refresh(input entry_t e, input logic we,
                                     input logic [REG_W-1:0] wrd, input logic [XLEN-1:0] wdata);
    entry_t r;
    r = e;
    if (we && (wrd != '0)) begin
      if (wrd == e.rs1) r.rd1 = wdata;
      if (wrd == e.rs2) r.rd2 = wdata;
    end
    return r;
  endfunction

  assign in_e = '{pc: pc_d, rd1: rd1_d, rd2: rd2_d, imm: imm_d,
                  rs1: rs1_d, rs2: rs2_d, rd: rd_d, ctrl: ctrl_d};

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Held entries after this cycle's write-back; the skid copy is what moves into main.
  entry_t main_ref, skid_ref;
`ifdef ID_EX_WB_REFRESH_EN
  assign main_ref = refresh(main_q, wb_regwrite, wb_rd, wb_data);
  assign skid_ref = refresh(skid_q, wb_regwrite, wb_rd, wb_data);
`else
  logic unused_wb;
  assign unused_wb = ^{wb_regwrite, wb_rd, wb_data};
  assign main_ref  = main_q;
  assign skid_ref  = skid_q;
`endif

  // Next-state and datapath selection
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          main_d  = in_e;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        main_d = main_ref;
        if (in_fire && out_fire) begin
          main_d = in_e;
        end else if (in_fire) begin
          skid_d  = in_e;
          state_d = S_TWO;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        main_d = main_ref;
        skid_d = skid_ref;
        if (out_fire) begin
          main_d  = skid_ref;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) state_d = S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  assign pc_e   = main_q.pc;
  assign rd1_e  = main_q.rd1;
  assign rd2_e  = main_q.rd2;
  assign imm_e  = main_q.imm;
  assign rs1_e  = main_q.rs1;
  assign rs2_e  = main_q.rs2;
  assign rd_e   = main_q.rd;
  assign ctrl_e = main_q.ctrl;

endmodule
